// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its data and instruction requesters, and the memory.
// The slave modport is the arbiter's view; the master modport is the requesters and memory.
interface mem_arbiter_if;
  logic [19:1] d_m_addr;
  logic [15:0] d_m_data_out;
  logic        d_m_wr_en;
  logic [1:0]  d_m_bytesel;
  logic        d_m_access;
  logic        d_m_ack;
  logic [15:0] d_m_data_in;

  logic [19:1] i_m_addr;
  logic        i_m_access;
  logic        i_m_ack;
  logic [15:0] i_m_data_in;

  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_out;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_m_access;
  logic        q_m_ack;
  logic [15:0] q_m_data_in;

  modport slave (
    input  d_m_addr, d_m_data_out, d_m_wr_en, d_m_bytesel, d_m_access,
    output d_m_ack, d_m_data_in,
    input  i_m_addr, i_m_access,
    output i_m_ack, i_m_data_in,
    output q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, q_m_access,
    input  q_m_ack, q_m_data_in
  );

  modport master (
    output d_m_addr, d_m_data_out, d_m_wr_en, d_m_bytesel, d_m_access,
    input  d_m_ack, d_m_data_in,
    output i_m_addr, i_m_access,
    input  i_m_ack, i_m_data_in,
    input  q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, q_m_access,
    output q_m_ack, q_m_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (data / instruction) to single-memory arbiter with a one-cycle gap after each grant.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate on ties; default build gives data fixed priority.
module mem_arbiter (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StData, StInstr, StGap} state_e;

  state_e state_q;
  logic   access_q;
  logic   grant_data;
  logic   grant_instr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_instr_q;

  // On a tie the port that did not win last time goes first.
  assign grant_data = bus.d_m_access & (~bus.i_m_access | last_instr_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_instr_q <= 1'b0;
    end else if (state_q == StIdle && (grant_data || grant_instr)) begin
      last_instr_q <= grant_instr;
    end
  end
`else
  assign grant_data = bus.d_m_access;
`endif

  assign grant_instr = bus.i_m_access & ~grant_data;

  // access_q mirrors "state is DATA or INSTR" so the memory request is a plain flop output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      access_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_data) begin
            state_q  <= StData;
            access_q <= 1'b1;
          end else if (grant_instr) begin
            state_q  <= StInstr;
            access_q <= 1'b1;
          end
        end
        StData, StInstr: begin
          if (bus.q_m_ack) begin
            state_q  <= StGap;
            access_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          access_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.q_m_addr     = '0;
    bus.q_m_data_out = '0;
    bus.q_m_wr_en    = 1'b0;
    bus.q_m_bytesel  = 2'b00;
    unique case (state_q)
      StData: begin
        bus.q_m_addr     = bus.d_m_addr;
        bus.q_m_data_out = bus.d_m_data_out;
        bus.q_m_wr_en    = bus.d_m_wr_en;
        bus.q_m_bytesel  = bus.d_m_bytesel;
      end
      StInstr: begin
        bus.q_m_addr    = bus.i_m_addr;
        bus.q_m_bytesel = 2'b11;
      end
      default: ;
    endcase
  end

  assign bus.q_m_access  = access_q;
  assign bus.d_m_ack     = bus.q_m_ack & (state_q == StData);
  assign bus.i_m_ack     = bus.q_m_ack & (state_q == StInstr);
  assign bus.d_m_data_in = bus.q_m_data_in;
  assign bus.i_m_data_in = bus.q_m_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model of who owns the memory,
// compared against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: owner 0 = nobody, 1 = data port, 2 = instruction port.
  int owner      = 0;
  bit cool       = 1'b0;
  bit last_instr = 1'b0;
  int prev_owner = 0;

  // Requester / memory agent state.
  bit          d_pending = 1'b0, d_acked_last = 1'b0;
  bit          i_pending = 1'b0, i_acked_last = 1'b0;
  logic [18:0] d_addr_v = '0, i_addr_v = '0;
  logic [15:0] d_dout_v = '0;
  logic        d_wr_v = 1'b0;
  logic [1:0]  d_bs_v = 2'b00;
  int          d_prob = 0, i_prob = 0, stray_prob = 0, rst_prob = 0;
  int          wait_fixed = 0, wait_max = 3, wait_cnt = 0;
  bit          noise = 1'b0, use_fixed = 1'b0, force_ack = 1'b0, rst_val = 1'b0;
  logic [15:0] fixed_data = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and apply the arbitration rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      owner      = 0;
      cool       = 1'b0;
      last_instr = 1'b0;
    end else if (owner != 0) begin
      if (bus.q_m_ack) begin
        owner = 0;
        cool  = 1'b1;
      end
    end else if (cool) begin
      cool = 1'b0;
    end else begin
      if (bus.d_m_access && bus.i_m_access) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        owner = last_instr ? 1 : 2;
`else
        owner = 1;
`endif
      end else if (bus.d_m_access) begin
        owner = 1;
      end else if (bus.i_m_access) begin
        owner = 2;
      end
      if (owner != 0) last_instr = (owner == 2);
    end
    #1;
  endtask

  // Drive requesters and memory for the cycle that has just begun.
  task automatic drive();
    bit d_tail, i_tail, ack;
    if (rst_prob > 0) rst_val = (int'($urandom_range(99)) >= rst_prob);
    reset = rst_val;

    d_tail = d_acked_last;
    d_acked_last = 1'b0;
    if (!d_pending && !d_tail) begin
      if (noise) begin
        d_addr_v = 19'($urandom);
        d_dout_v = 16'($urandom);
        d_wr_v   = 1'($urandom);
        d_bs_v   = 2'($urandom);
      end
      if (int'($urandom_range(99)) < d_prob) d_pending = 1'b1;
    end
    i_tail = i_acked_last;
    i_acked_last = 1'b0;
    if (!i_pending && !i_tail) begin
      if (noise) i_addr_v = 19'($urandom);
      if (int'($urandom_range(99)) < i_prob) i_pending = 1'b1;
    end
    bus.d_m_access   = d_pending | d_tail;
    bus.d_m_addr     = d_addr_v;
    bus.d_m_data_out = d_dout_v;
    bus.d_m_wr_en    = d_wr_v;
    bus.d_m_bytesel  = d_bs_v;
    bus.i_m_access   = i_pending | i_tail;
    bus.i_m_addr     = i_addr_v;

    if (owner != 0) begin
      if (prev_owner == 0)
        wait_cnt = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(wait_max));
      ack = (wait_cnt == 0);
      if (!ack) wait_cnt--;
    end else begin
      ack = force_ack || (int'($urandom_range(99)) < stray_prob);
    end
    bus.q_m_ack     = ack;
    bus.q_m_data_in = use_fixed ? fixed_data : 16'($urandom);
    if (ack && owner == 1) begin
      d_pending    = 1'b0;
      d_acked_last = 1'b1;
    end
    if (ack && owner == 2) begin
      i_pending    = 1'b0;
      i_acked_last = 1'b1;
    end
    prev_owner = owner;
  endtask

  task automatic step();
    tick();
    drive();
    @(negedge clk);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("q_m_access", bus.q_m_access, 32'(owner != 0));
      chk("q_m_addr", bus.q_m_addr,
          owner == 1 ? bus.d_m_addr : owner == 2 ? bus.i_m_addr : 19'h0);
      chk("q_m_data_out", bus.q_m_data_out, owner == 1 ? bus.d_m_data_out : 16'h0);
      chk("q_m_wr_en", bus.q_m_wr_en, owner == 1 ? bus.d_m_wr_en : 1'b0);
      chk("q_m_bytesel", bus.q_m_bytesel,
          owner == 1 ? bus.d_m_bytesel : owner == 2 ? 2'b11 : 2'b00);
      chk("d_m_ack", bus.d_m_ack, 32'(owner == 1 && bus.q_m_ack));
      chk("i_m_ack", bus.i_m_ack, 32'(owner == 2 && bus.q_m_ack));
      chk("d_m_data_in", bus.d_m_data_in, bus.q_m_data_in);
      chk("i_m_data_in", bus.i_m_data_in, bus.q_m_data_in);
    end
  end

  initial begin
    int acc, dack, iack, first, ackc, grants, d_ack_c, i_ack_c, c0;
    bit seen;
    logic [15:0] got;

    reset = 1'b0;
    bus.d_m_addr = '0; bus.d_m_data_out = '0; bus.d_m_wr_en = 1'b0; bus.d_m_bytesel = '0;
    bus.d_m_access = 1'b0; bus.i_m_addr = '0; bus.i_m_access = 1'b0;
    bus.q_m_ack = 1'b0; bus.q_m_data_in = '0;

    // Reset with requests, noisy inputs and a stuck memory ack: nothing may leak out.
    rst_val = 1'b0; noise = 1'b1; force_ack = 1'b1; d_pending = 1'b1; i_pending = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    step();
    chk("rst_acc", bus.q_m_access, 0);
    chk("rst_dack", bus.d_m_ack, 0);
    chk("rst_iack", bus.i_m_ack, 0);
    chk("rst_wr", bus.q_m_wr_en, 0);
    chk("rst_addr", bus.q_m_addr, 0);
    chk("rst_dout", bus.q_m_data_out, 0);
    chk("rst_bs", bus.q_m_bytesel, 0);
    d_pending = 1'b0; i_pending = 1'b0; force_ack = 1'b0; noise = 1'b0;
    step();

    // Data read, two wait states, plus the access tail after the ack.
    rst_val = 1'b1; wait_fixed = 2; use_fixed = 1'b1; fixed_data = 16'hBEEF;
    d_addr_v = 19'h12345; d_dout_v = '0; d_wr_v = 1'b0; d_bs_v = 2'b11; d_pending = 1'b1;
    acc = 0; dack = 0; iack = 0; first = -1; ackc = -1; got = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ackc >= 0 && c <= ackc + 2) chk("tail_gap_acc", bus.q_m_access, 0);
      if (bus.q_m_access) begin
        acc++;
        if (first < 0) first = c;
      end
      if (bus.d_m_ack) begin
        dack++;
        got  = bus.d_m_data_in;
        ackc = c;
      end
      if (bus.i_m_ack) iack++;
    end
    chk("rd_acc_cycles", acc, 3);
    chk("rd_dack_count", dack, 1);
    chk("rd_iack_count", iack, 0);
    chk("rd_data", got, 16'hBEEF);
    chk("rd_first_acc", first, 1);
    chk("rd_ack_latency", ackc - first, 2);
    use_fixed = 1'b0;

    // Data write, zero-wait memory: fields visible only in the single grant cycle.
    wait_fixed = 0; d_addr_v = 19'h0_7abc; d_dout_v = 16'hA55A; d_wr_v = 1'b1; d_bs_v = 2'b01;
    d_pending = 1'b1; grants = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.q_m_access) begin
        grants++;
        chk("wr_en", bus.q_m_wr_en, 1);
        chk("wr_bs", bus.q_m_bytesel, 2'b01);
        chk("wr_data", bus.q_m_data_out, 16'hA55A);
      end else begin
        chk("wr_idle_en", bus.q_m_wr_en, 0);
        chk("wr_idle_data", bus.q_m_data_out, 0);
      end
    end
    chk("wr_grant_cycles", grants, 1);
    d_wr_v = 1'b0;

    // Simultaneous requests, one wait state each.
    wait_fixed = 1; d_addr_v = 19'h1_1111; i_addr_v = 19'h2_2222; d_bs_v = 2'b11;
    d_pending = 1'b1; i_pending = 1'b1; d_ack_c = -1; i_ack_c = -1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.d_m_ack) d_ack_c = c;
      if (bus.i_m_ack) i_ack_c = c;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie_first_ack", i_ack_c, 2);
    chk("tie_second_ack", d_ack_c, 6);
`else
    chk("tie_first_ack", d_ack_c, 2);
    chk("tie_second_ack", i_ack_c, 6);
`endif

    // Reset while a data grant waits on the memory, then stray acks.
    wait_fixed = 5; d_addr_v = 19'h3_0303; d_dout_v = 16'h1234; d_wr_v = 1'b1; d_bs_v = 2'b10;
    d_pending = 1'b1; seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      step();
      seen = bus.q_m_access;
    end
    chk("rstmid_granted", seen, 1);
    rst_val = 1'b0;
    step();
    chk("rstmid_pre_acc", bus.q_m_access, 1);
    d_pending = 1'b0; force_ack = 1'b1;
    step();
    chk("rstmid_acc", bus.q_m_access, 0);
    chk("rstmid_dack", bus.d_m_ack, 0);
    chk("rstmid_wr", bus.q_m_wr_en, 0);
    rst_val = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stray_acc", bus.q_m_access, 0);
      chk("stray_dack", bus.d_m_ack, 0);
      chk("stray_iack", bus.i_m_ack, 0);
    end
    force_ack = 1'b0; d_wr_v = 1'b0;

    // Back-to-back zero-wait instruction fetches: q_m_access repeats 1,0,0.
    wait_fixed = 0; i_addr_v = 19'h4_4444; i_prob = 100; c0 = -1;
    for (int c = 0; c < 13; c++) begin
      step();
      if (c0 < 0 && bus.q_m_access) c0 = c;
      if (c0 >= 0) begin
        chk("fetch_acc", bus.q_m_access, 32'((c - c0) % 3 == 0));
        chk("fetch_iack", bus.i_m_ack, 32'((c - c0) % 3 == 0));
      end
    end
    chk("fetch_started", 32'(c0 >= 0), 1);
    i_prob = 0;
    for (int c = 0; c < 4; c++) step();

    // Random traffic, waits, stray acks and occasional resets.
    noise = 1'b1; wait_fixed = -1; wait_max = 3; stray_prob = 10; rst_prob = 2;
    for (int blk = 0; blk < 6; blk++) begin
      d_prob = int'($urandom_range(100));
      i_prob = int'($urandom_range(100));
      for (int c = 0; c < 500; c++) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled on rising clk; 0 = reset asserted.
REQ-003 d_m_addr  input  19  data-port word address [19:1].
REQ-004 d_m_data_out  input  16  data-port write data.
REQ-005 d_m_wr_en / d_m_bytesel  input  1/2  data-port write strobe / byte lanes [1:0].
REQ-006 d_m_access  input  1  data-port request; held high until one cycle after its ack.
REQ-007 d_m_ack  output  1  data-port completion.
REQ-008 i_m_addr  input  19  instruction-port word address [19:1]; read-only port.
REQ-009 i_m_access / i_m_ack  input/output  1/1  instruction-port request / completion.
REQ-010 d_m_data_in, i_m_data_in  output  16  read data to each port.
REQ-011 q_m_addr  output  19  memory word address.
REQ-012 q_m_data_out / q_m_wr_en / q_m_bytesel  output  16/1/2  memory write data / strobe / byte lanes.
REQ-013 q_m_access / q_m_ack / q_m_data_in  output/input/input  1/1/16  memory request / completion / read data.

Function
REQ-014 The FSM SHALL have four states: IDLE, DATA, INSTR, GAP.
REQ-015 IDLE: if d_m_access -> DATA; else if i_m_access -> INSTR; else stay (fixed priority, data wins a tie).
REQ-016 DATA/INSTR: hold until q_m_ack=1, then -> GAP; a requester dropping access while granted SHALL NOT abort the grant.
REQ-017 GAP: one cycle with no grant, unconditionally -> IDLE; absorbs the requester's one-cycle access tail after ack.
REQ-018 q_m_access SHALL be 1 exactly in DATA and INSTR states (registered, no combinational path from d/i_m_access).
REQ-019 q_m_addr/q_m_data_out/q_m_wr_en/q_m_bytesel SHALL be muxed from the granted port; in IDLE/GAP all SHALL be 0.
REQ-020 In INSTR, q_m_wr_en SHALL be 0 and q_m_bytesel SHALL be 2'b11.
REQ-021 d_m_ack = q_m_ack AND state==DATA; i_m_ack = q_m_ack AND state==INSTR (combinational, same cycle).
REQ-022 q_m_ack outside DATA/INSTR SHALL be ignored and SHALL NOT change state.
REQ-023 d_m_data_in and i_m_data_in SHALL both equal q_m_data_in combinationally; only the ack qualifies validity.
REQ-024 Latency: request seen in IDLE at cycle N -> q_m_access=1 at N+1; ack at M -> GAP at M+1, IDLE at M+2, earliest next q_m_access at M+3.
REQ-025 A zero-wait memory (q_m_ack in first DATA/INSTR cycle) SHALL be supported: grant lasts exactly one cycle.
REQ-026 At most one of d_m_ack, i_m_ack SHALL be 1 in any cycle.

Reset
REQ-027 reset=0 at a rising edge SHALL force state IDLE, last-grant flag to DATA, regardless of current state.
REQ-028 During and after reset: q_m_access, d_m_ack, i_m_ack, q_m_wr_en = 0; q_m_addr, q_m_data_out, q_m_bytesel = 0.
REQ-029 Reset mid-transaction SHALL abandon the grant; no ack SHALL be forwarded from that transaction.

Configuration
REQ-030 Macro MEM_ARB_ROUND_ROBIN_EN: when defined, IDLE tie (both access=1) SHALL grant the port not granted last; last-grant flag updates on each entry to DATA/INSTR.
REQ-031 Without MEM_ARB_ROUND_ROBIN_EN: fixed data priority per REQ-015; last-grant flag not implemented.

Verification
REQ-032 Data read alone: d_m_access=1, d_m_addr=19'h12345, mem acks after 2 wait cycles with 16'hBEEF -> q_m_access 3 cycles, d_m_ack 1 cycle with d_m_data_in=16'hBEEF, i_m_ack=0.
REQ-033 Data write: d_m_wr_en=1, bytesel=2'b01, data 16'hA55A -> q_m_wr_en=1, q_m_bytesel=2'b01, q_m_data_out=16'hA55A only while granted.
REQ-034 Simultaneous requests (both held until ack) -> default build: DATA then GAP then INSTR; RR build: DATA, INSTR, DATA alternation over 3 transactions.
REQ-035 Access tail: requester keeps access=1 one cycle after ack -> no second transaction to that port; GAP observed; q_m_access=0 for 2 cycles.
REQ-036 Reset=0 asserted in DATA with q_m_ack pending -> next cycle q_m_access=0, state IDLE; stray q_m_ack=1 afterwards produces no d_m_ack/i_m_ack.
REQ-037 Zero-wait memory, back-to-back instruction fetches -> q_m_access pattern 1,0,0,1 per fetch; i_m_ack high exactly once per fetch.
